pipeline_stall_controller: RTL and testbench

- Consumer of the pipeline's RAW-hazard flag. It turns hazard, taken-branch and SRAM-wait indications into per-stage freeze, flush and bubble controls for the 5-stage ARM pipeline.
- Sits beside the hazard detection unit in the top-level datapath. Drives the PC register, the IF/ID register, the ID/EX register and the EXE/MEM/WB registers.
- Also keeps stall and flush statistics and a memory-wait watchdog.

---
 rtl/pipeline_stall_controller_pkg.sv | 30 +++
 rtl/pipeline_stall_controller_sat_counter.sv | 27 ++
 rtl/pipeline_stall_controller.sv | 120 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall controller: FSM state
// encoding, the bundled per-stage control word and the default watchdog limit.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HAZ      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_freeze;
    logic if_id_freeze;
    logic if_id_flush;
    logic id_exe_bubble;
    logic pipe_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE     = '{pc_freeze: 1'b0, if_id_freeze: 1'b0, if_id_flush: 1'b0,
                                      id_exe_bubble: 1'b0, pipe_freeze: 1'b0};
  localparam ctrl_t CTRL_MEM_WAIT = '{pc_freeze: 1'b1, if_id_freeze: 1'b1, if_id_flush: 1'b0,
                                      id_exe_bubble: 1'b0, pipe_freeze: 1'b1};
  localparam ctrl_t CTRL_FLUSH    = '{pc_freeze: 1'b0, if_id_freeze: 1'b0, if_id_flush: 1'b1,
                                      id_exe_bubble: 1'b1, pipe_freeze: 1'b0};
  localparam ctrl_t CTRL_HAZARD   = '{pc_freeze: 1'b1, if_id_freeze: 1'b1, if_id_flush: 1'b0,
                                      id_exe_bubble: 1'b1, pipe_freeze: 1'b0};

  localparam int DEFAULT_MEM_TIMEOUT = 64;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Width-parameterised up-counter that stops at MAX; clr wins over inc.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != MAX)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Turns hazard, taken-branch and SRAM-wait indications into per-stage freeze,
// flush and bubble controls; also keeps stall/flush statistics and a wait watchdog.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             stat_clr,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] RUN      = ST_RUN;
  localparam logic [1:0] HAZ      = ST_HAZ;
  localparam logic [1:0] MEM_WAIT = ST_MEM_WAIT;

  logic            mem_wait;
  ctrl_t           ctrl;
  logic [1:0]      state_reg;
  logic [1:0]      state_next;
  logic [WD_W-1:0] wd_count;
  logic            mem_timeout_reg;

  assign mem_wait = mem_req & ~mem_ready;

  // A branch held during a memory wait is simply deferred: EXE is frozen so
  // branch_taken is still high when the wait ends.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (rst) begin
      if (mem_wait) begin
        ctrl = CTRL_MEM_WAIT;
      end else if (branch_taken) begin
        ctrl = CTRL_FLUSH;
      end else if (hazard) begin
        ctrl = CTRL_HAZARD;
      end
    end
  end

  assign pc_freeze     = ctrl.pc_freeze;
  assign if_id_freeze  = ctrl.if_id_freeze;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_exe_bubble = ctrl.id_exe_bubble;
  assign pipe_freeze   = ctrl.pipe_freeze;

  always_comb begin
    state_next = RUN;
    if (mem_wait) begin
      state_next = MEM_WAIT;
    end else if (hazard && !branch_taken) begin
      state_next = HAZ;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state_o = state_reg;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (ctrl.pc_freeze),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr),
    .inc   (ctrl.if_id_flush),
    .count (flush_cnt)
  );

  // Watchdog counts consecutive wait cycles only; any non-wait cycle restarts it.
  sat_counter #(.W(WD_W), .MAX(WD_W'(MEM_TIMEOUT))) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (stat_clr | ~mem_wait),
    .inc   (mem_wait),
    .count (wd_count)
  );

  // Set on the same edge the watchdog reaches MEM_TIMEOUT, then sticky.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_timeout_reg <= 1'b0;
    end else if (stat_clr) begin
      mem_timeout_reg <= 1'b0;
    end else if (mem_wait && (wd_count >= WD_W'(MEM_TIMEOUT - 1))) begin
      mem_timeout_reg <= 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_reg;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: dut_a (CNT_W=16, MEM_TIMEOUT=4) and dut_b (CNT_W=3, default
// timeout) share all inputs; controls packed as {pc,if_id_frz,flush,bubble,pipe}.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst, hazard, branch_taken, mem_req, mem_ready, stat_clr;

  logic        a_pc, a_ifz, a_flush, a_bub, a_pipe, a_tmo;
  logic [1:0]  a_state;
  logic [15:0] a_stall, a_flcnt;
  logic        b_pc, b_ifz, b_flush, b_bub, b_pipe, b_tmo;
  logic [1:0]  b_state;
  logic [2:0]  b_stall, b_flcnt;

  logic [4:0] ctrl_a, ctrl_b;
  assign ctrl_a = {a_pc, a_ifz, a_flush, a_bub, a_pipe};
  assign ctrl_b = {b_pc, b_ifz, b_flush, b_bub, b_pipe};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.CNT_W(16), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .stat_clr(stat_clr),
    .pc_freeze(a_pc), .if_id_freeze(a_ifz), .if_id_flush(a_flush),
    .id_exe_bubble(a_bub), .pipe_freeze(a_pipe), .state_o(a_state),
    .stall_cnt(a_stall), .flush_cnt(a_flcnt), .mem_timeout(a_tmo)
  );

  pipeline_stall_controller #(.CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .stat_clr(stat_clr),
    .pc_freeze(b_pc), .if_id_freeze(b_ifz), .if_id_flush(b_flush),
    .id_exe_bubble(b_bub), .pipe_freeze(b_pipe), .state_o(b_state),
    .stall_cnt(b_stall), .flush_cnt(b_flcnt), .mem_timeout(b_tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; hazard = 1'b1; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; stat_clr = 1'b0;
    tick(); tick();
    total++; if (ctrl_a !== 5'b00000) begin $display("FAIL reset_ctrl got=%b exp=%b", ctrl_a, 5'b00000); bad++; end
    total++; if (a_stall !== 16'd0) begin $display("FAIL reset_stall got=%0d exp=0", a_stall); bad++; end
    total++; if (a_state !== 2'd0) begin $display("FAIL reset_state got=%0d exp=0", a_state); bad++; end
    total++; if (a_tmo !== 1'b0) begin $display("FAIL reset_tmo got=%b exp=0", a_tmo); bad++; end
    rst = 1'b1;
    #1;
    total++; if (ctrl_a !== 5'b11010) begin $display("FAIL release_ctrl got=%b exp=%b", ctrl_a, 5'b11010); bad++; end
    total++; if (a_state !== 2'd0) begin $display("FAIL release_state_lag got=%0d exp=0", a_state); bad++; end
    tick();
    total++; if (a_state !== 2'd1) begin $display("FAIL release_state got=%0d exp=1", a_state); bad++; end
    total++; if (a_stall !== 16'd1) begin $display("FAIL release_stall got=%0d exp=1", a_stall); bad++; end
    hazard = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_hazard();
    clear_stats();
    hazard = 1'b1;
    tick(); tick(); tick();
    total++; if (a_state !== 2'd1) begin $display("FAIL haz_state got=%0d exp=1", a_state); bad++; end
    hazard = 1'b0;
    #1;
    total++; if (ctrl_a !== 5'b00000) begin $display("FAIL haz_drop_ctrl got=%b exp=%b", ctrl_a, 5'b00000); bad++; end
    total++; if (a_state !== 2'd1) begin $display("FAIL haz_drop_state_lag got=%0d exp=1", a_state); bad++; end
    tick();
    total++; if (a_state !== 2'd0) begin $display("FAIL haz_run_state got=%0d exp=0", a_state); bad++; end
    total++; if (a_stall !== 16'd3) begin $display("FAIL haz_stall got=%0d exp=3", a_stall); bad++; end
    total++; if (a_flcnt !== 16'd0) begin $display("FAIL haz_flush got=%0d exp=0", a_flcnt); bad++; end
    $display("test_hazard done");
  endtask

  task automatic test_branch_over_hazard();
    hazard = 1'b1; branch_taken = 1'b1;
    #1;
    total++; if (ctrl_a !== 5'b00110) begin $display("FAIL br_ctrl got=%b exp=%b", ctrl_a, 5'b00110); bad++; end
    tick();
    total++; if (a_flcnt !== 16'd1) begin $display("FAIL br_flush got=%0d exp=1", a_flcnt); bad++; end
    total++; if (a_stall !== 16'd3) begin $display("FAIL br_stall got=%0d exp=3", a_stall); bad++; end
    total++; if (a_state !== 2'd0) begin $display("FAIL br_state got=%0d exp=0", a_state); bad++; end
    hazard = 1'b0; branch_taken = 1'b0;
    tick();
    $display("test_branch_over_hazard done");
  endtask

  task automatic test_mem_wait_branch();
    clear_stats();
    mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (ctrl_a !== 5'b11001) begin $display("FAIL mw_ctrl[%0d] got=%b exp=%b", i, ctrl_a, 5'b11001); bad++; end
      tick();
      total++; if (a_state !== 2'd2) begin $display("FAIL mw_state[%0d] got=%0d exp=2", i, a_state); bad++; end
    end
    mem_ready = 1'b1;
    #1;
    total++; if (ctrl_a !== 5'b00110) begin $display("FAIL mw_flush_ctrl got=%b exp=%b", ctrl_a, 5'b00110); bad++; end
    tick();
    total++; if (a_stall !== 16'd5) begin $display("FAIL mw_stall got=%0d exp=5", a_stall); bad++; end
    total++; if (a_flcnt !== 16'd1) begin $display("FAIL mw_flush got=%0d exp=1", a_flcnt); bad++; end
    total++; if (a_state !== 2'd0) begin $display("FAIL mw_end_state got=%0d exp=0", a_state); bad++; end
    // Stray mem_ready without a request must not mask the hazard.
    mem_req = 1'b0; branch_taken = 1'b0; hazard = 1'b1;
    #1;
    total++; if (ctrl_a !== 5'b11010) begin $display("FAIL stray_ready_ctrl got=%b exp=%b", ctrl_a, 5'b11010); bad++; end
    tick();
    total++; if (a_state !== 2'd1) begin $display("FAIL stray_ready_state got=%0d exp=1", a_state); bad++; end
    hazard = 1'b0; mem_ready = 1'b0;
    tick();
    $display("test_mem_wait_branch done");
  endtask

  task automatic test_timeout();
    clear_stats();
    total++; if (a_tmo !== 1'b0) begin $display("FAIL tmo_cleared got=%b exp=0", a_tmo); bad++; end
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++; if (a_tmo !== (k >= 4)) begin $display("FAIL tmo_cycle[%0d] got=%b exp=%b", k, a_tmo, (k >= 4)); bad++; end
      total++; if (ctrl_a !== 5'b11001) begin $display("FAIL tmo_ctrl[%0d] got=%b exp=%b", k, ctrl_a, 5'b11001); bad++; end
    end
    total++; if (b_tmo !== 1'b0) begin $display("FAIL tmo_default_early got=%b exp=0", b_tmo); bad++; end
    mem_req = 1'b0;
    tick();
    total++; if (a_tmo !== 1'b1) begin $display("FAIL tmo_sticky got=%b exp=1", a_tmo); bad++; end
    clear_stats();
    total++; if (a_tmo !== 1'b0) begin $display("FAIL tmo_statclr got=%b exp=0", a_tmo); bad++; end
    total++; if (a_stall !== 16'd0) begin $display("FAIL statclr_stall got=%0d exp=0", a_stall); bad++; end
    total++; if (a_flcnt !== 16'd0) begin $display("FAIL statclr_flush got=%0d exp=0", a_flcnt); bad++; end
    $display("test_timeout done");
  endtask

  task automatic test_saturate();
    hazard = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 6) begin
        total++; if (b_stall !== 3'd6) begin $display("FAIL sat_pre got=%0d exp=6", b_stall); bad++; end
      end
    end
    total++; if (b_stall !== 3'd7) begin $display("FAIL sat_hold got=%0d exp=7", b_stall); bad++; end
    total++; if (a_stall !== 16'd10) begin $display("FAIL sat_wide got=%0d exp=10", a_stall); bad++; end
    hazard = 1'b0;
    tick();
    $display("test_saturate done");
  endtask

  task automatic test_reset_mid_stall();
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    total++; if (ctrl_a !== 5'b00000) begin $display("FAIL rststall_ctrl_a got=%b exp=%b", ctrl_a, 5'b00000); bad++; end
    total++; if (ctrl_b !== 5'b00000) begin $display("FAIL rststall_ctrl_b got=%b exp=%b", ctrl_b, 5'b00000); bad++; end
    tick();
    total++; if (a_state !== 2'd0) begin $display("FAIL rststall_state got=%0d exp=0", a_state); bad++; end
    total++; if (a_stall !== 16'd0) begin $display("FAIL rststall_stall got=%0d exp=0", a_stall); bad++; end
    rst = 1'b1; mem_req = 1'b0;
    tick();
    $display("test_reset_mid_stall done");
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_branch_over_hazard();
    test_mem_wait_branch();
    test_timeout();
    test_saturate();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
